// File: rtl/ula_seq.sv
// Sequencer for an external 8-bit add/sub ALU: one command in flight,
// valid/ready command and result channels, accumulator chaining with Z/N/V flags.
module ula_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic       ula_op,
  input  logic [7:0] ula_s,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       z_q, z_d;
  logic       n_q, n_d;
  logic       v_q, v_d;
  logic       ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= OP_LOAD;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  // Subtraction overflows when operand signs differ; addition when they match.
  always_comb begin
    ovf = 1'b0;
    if (op_q == OP_SUB)
      ovf = (acc_q[7] != b_q[7]) && (ula_s[7] != acc_q[7]);
    else
      ovf = (acc_q[7] == b_q[7]) && (ula_s[7] != acc_q[7]);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          b_d  = cmd_data;
          op_d = cmd_op;
          unique case (cmd_op)
            OP_LOAD: begin
              acc_d   = cmd_data;
              z_d     = (cmd_data == 8'h00);
              n_d     = cmd_data[7];
              v_d     = 1'b0;
              state_d = RESP;
            end
            OP_CLEAR: begin
              acc_d   = 8'h00;
              z_d     = 1'b1;
              n_d     = 1'b0;
              v_d     = 1'b0;
              state_d = RESP;
            end
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        acc_d   = ula_s;
        z_d     = (ula_s == 8'h00);
        n_d     = ula_s[7];
        v_d     = ovf;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign ula_a     = acc_q;
  assign ula_b     = b_q;
  assign ula_op    = (state_q == EXEC) && (op_q == OP_SUB);
  assign res_data  = acc_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: external ALU model, command table with
// chained accumulator, then backpressure, async reset and streaming cases.
module tb_ula_seq;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic       ula_op;
  logic [7:0] ula_s;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  int n_chk;
  int n_fail;

  ula_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_op    (ula_op),
    .ula_s     (ula_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  assign ula_s = ula_op ? (ula_a - ula_b) : (ula_a + ula_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       v;
    int         lat;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int  lat;
    bit  got;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (res_valid) got = 1;
      else begin
        chk("ula_op_exec", ula_op, (v.op == OP_SUB));
        chk("cmd_ready_busy", cmd_ready, 0);
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!got) chk("res_valid_timeout", 0, 1);
    chk("latency", lat, v.lat);
    chk("res_data", res_data, v.res);
    chk("flag_z", flag_z, v.z);
    chk("flag_n", flag_n, v.n);
    chk("flag_v", flag_v, v.v);
    chk("ula_a", ula_a, v.res);
    chk("ula_b", ula_b, v.data);
    chk("ula_op_resp", ula_op, 0);
    chk("cmd_ready_resp", cmd_ready, 0);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("res_valid_after", res_valid, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   acc_cnt;
    int   res_cnt;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h00;
    res_ready = 1'b0;

    tv[0]  = '{OP_LOAD,  8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1};
    tv[1]  = '{OP_ADD,   8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 2};
    tv[2]  = '{OP_SUB,   8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 2};
    tv[3]  = '{OP_LOAD,  8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1};
    tv[4]  = '{OP_ADD,   8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 2};
    tv[5]  = '{OP_LOAD,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tv[6]  = '{OP_SUB,   8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 2};
    tv[7]  = '{OP_LOAD,  8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1};
    tv[8]  = '{OP_SUB,   8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 2};
    tv[9]  = '{OP_LOAD,  8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 1};
    tv[10] = '{OP_CLEAR, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tv[11] = '{OP_ADD,   8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 2};
    tv[12] = '{OP_ADD,   8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 2};

    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_flags", {flag_z, flag_n, flag_v}, 0);
    chk("rst_ula_op", ula_op, 0);
    chk("rst_ula_b", ula_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run(tv[i]);

    // backpressure: acc = 0x01, ADD 0x02 held for 3 cycles
    @(negedge clk);
    cmd_op    = OP_ADD;
    cmd_data  = 8'h02;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_res_valid0", res_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_op    = OP_LOAD;
      cmd_data  = 8'h77;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 8'h03);
      chk("bp_flags", {flag_z, flag_n, flag_v}, 3'b000);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("bp_release_ready", cmd_ready, 1);
    chk("bp_release_valid", res_valid, 0);
    chk("bp_load_ignored", res_data, 8'h03);

    // asynchronous reset in the middle of EXEC
    @(negedge clk);
    cmd_op    = OP_ADD;
    cmd_data  = 8'h10;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ar_in_exec", cmd_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cmd_ready", cmd_ready, 1);
    chk("ar_res_valid", res_valid, 0);
    chk("ar_res_data", res_data, 0);
    chk("ar_ula_op", ula_op, 0);
    chk("ar_ula_b", ula_b, 0);
    chk("ar_flags", {flag_z, flag_n, flag_v}, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("ar_no_res_valid", res_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{OP_LOAD, 8'h22, 8'h22, 1'b0, 1'b0, 1'b0, 1};
    run(v);

    // streaming: cmd_valid and res_ready held high, ADD 0x01 each time
    acc_cnt = 0;
    res_cnt = 0;
    @(negedge clk);
    cmd_op    = OP_ADD;
    cmd_data  = 8'h01;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cmd_valid && cmd_ready) acc_cnt++;
      if (res_valid && res_ready) res_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk("bb_accepts", acc_cnt, 4);
    chk("bb_results", res_cnt, 4);
    chk("bb_acc", res_data, 8'h26);
    chk("bb_idle", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: cmd_valid  input  1  command offered.
REQ-004 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-005 SHALL have port: cmd_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-006 SHALL have port: cmd_data  input  8  operand (ignored for CLEAR).
REQ-007 SHALL have port: ula_a  output  8  ALU operand A; always equals acc.
REQ-008 SHALL have port: ula_b  output  8  ALU operand B; always equals b_reg.
REQ-009 SHALL have port: ula_op  output  1  ALU op (0 add, 1 subtract A-B); nonzero only in EXEC for SUB.
REQ-010 SHALL have port: ula_s  input  8  ALU result, combinational from ula_a/ula_b/ula_op, modulo 256.
REQ-011 SHALL have port: res_valid  output  1  result available.
REQ-012 SHALL have port: res_ready  input  1  result consumed when res_valid && res_ready at a rising edge.
REQ-013 SHALL have port: res_data  output  8  equals acc.
REQ-014 SHALL have port: flag_z  output  1  zero flag of last result.
REQ-015 SHALL have port: flag_n  output  1  res_data[7].
REQ-016 SHALL have port: flag_v  output  1  signed overflow of last ADD/SUB.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready = (state == IDLE), combinational.
REQ-018 On accept in IDLE: b_reg <= cmd_data, op_reg <= cmd_op; ADD/SUB -> EXEC; LOAD -> acc <= cmd_data, RESP; CLEAR -> acc <= 0, RESP.
REQ-019 In EXEC (exactly one cycle): ula_op = 1 for SUB, 0 for ADD; at cycle end acc <= ula_s, flags updated, -> RESP.
REQ-020 Latency: res_valid high on the 2nd rising edge after accept for ADD/SUB, the 1st for LOAD/CLEAR.
REQ-021 In RESP: res_valid = 1; res_data and flags stable; -> IDLE on res_ready; hold indefinitely while res_ready = 0.
REQ-022 res_valid SHALL be 0 in IDLE and EXEC; no new command accepted until the result is consumed (one command in flight).
REQ-023 flag_z = (acc == 0); flag_n = acc[7]; both update whenever acc updates.
REQ-024 flag_v ADD: a[7]==b[7] && s[7]!=a[7]; SUB: a[7]!=b[7] && s[7]!=a[7] (a = acc before, b = b_reg, s = ula_s); LOAD/CLEAR set flag_v = 0.
REQ-025 Arithmetic wraps modulo 256; no carry output; acc persists across commands (accumulator chaining).
REQ-026 cmd_valid while not IDLE SHALL have no effect; cmd_data/cmd_op sampled only on accept.
REQ-027 res_ready while res_valid = 0 SHALL be ignored.

Reset
REQ-028 rst_n = 0 SHALL immediately force state IDLE, acc = 0, b_reg = 0, op_reg = 00, flag_z = 0, flag_n = 0, flag_v = 0, res_valid = 0, ula_op = 0.
REQ-029 cmd_ready SHALL read 1 during and after reset (IDLE); reset mid-EXEC or mid-RESP SHALL discard the operation with no res_valid pulse.

Verification
REQ-030 Reset, LOAD 0x05, then ADD 0x03 -> res_data 0x08, z=0 n=0 v=0, res_valid on 2nd edge after ADD accept, ula_op 0 throughout.
REQ-031 acc 0x08, SUB 0x08 -> ula_op = 1 in EXEC only, res_data 0x00, z=1 n=0 v=0.
REQ-032 LOAD 0x7F, ADD 0x01 -> res_data 0x80, n=1 v=1; then LOAD 0x00, SUB 0x01 -> 0xFF, n=1 v=0; then SUB 0x7F from 0x80 (LOAD 0x80) -> 0x01, v=1.
REQ-033 Backpressure: ADD completes with res_ready = 0 for 3 cycles -> res_valid, res_data, flags held, cmd_ready = 0, cmd_valid pulses ignored; res_ready = 1 -> IDLE next edge.
REQ-034 rst_n asserted asynchronously during EXEC of ADD 0x10 -> outputs at reset values immediately, no res_valid; next LOAD 0x22 -> res_data 0x22, latency 1.
REQ-035 CLEAR after acc = 0x55 -> res_data 0x00, z=1 n=0 v=0, latency 1; back-to-back commands with cmd_valid held high -> one accept per completed result.
